// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation at the tail, out-of-order CDB completion,
// in-order retirement from the head, plus combinational operand-tag lookup with CDB bypass.
module reorder_buffer #(
  parameter int ROB_DEPTH = 8,
  parameter int IDX_W     = 3,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              alloc_valid_in,
  input  logic [REG_W-1:0]  alloc_dest_reg_in,
  input  logic              alloc_writes_reg_in,
  output logic              alloc_ready_out,
  output logic [IDX_W-1:0]  alloc_idx_out,
  input  logic              cdb_valid_in,
  input  logic [IDX_W-1:0]  cdb_rob_idx_in,
  input  logic [DATA_W-1:0] cdb_value_in,
  input  logic [IDX_W-1:0]  src1_idx_in,
  output logic              src1_ready_out,
  output logic [DATA_W-1:0] src1_value_out,
  input  logic [IDX_W-1:0]  src2_idx_in,
  output logic              src2_ready_out,
  output logic [DATA_W-1:0] src2_value_out,
  output logic              commit_valid_out,
  output logic [IDX_W-1:0]  commit_rob_idx_out,
  output logic [REG_W-1:0]  commit_dest_reg_out,
  output logic              commit_writes_reg_out,
  output logic [DATA_W-1:0] commit_value_out,
  output logic [IDX_W:0]    count_out
);

  logic [ROB_DEPTH-1:0] busy_q, busy_d;
  logic [ROB_DEPTH-1:0] ready_q, ready_d;
  logic [ROB_DEPTH-1:0] writes_q, writes_d;
  logic [REG_W-1:0]     dest_q [ROB_DEPTH];
  logic [REG_W-1:0]     dest_d [ROB_DEPTH];
  logic [DATA_W-1:0]    value_q [ROB_DEPTH];
  logic [DATA_W-1:0]    value_d [ROB_DEPTH];
  logic [IDX_W-1:0]     head_q, head_d;
  logic [IDX_W-1:0]     tail_q, tail_d;
  logic [IDX_W:0]       count_q, count_d;

  logic alloc_fire;
  logic commit_fire;
  logic src1_hit;
  logic src2_hit;

  assign alloc_ready_out = (count_q < (IDX_W+1)'(ROB_DEPTH));
  assign alloc_idx_out   = tail_q;
  assign alloc_fire      = alloc_valid_in && alloc_ready_out;

  assign commit_fire           = busy_q[head_q] && ready_q[head_q];
  assign commit_valid_out      = commit_fire;
  assign commit_rob_idx_out    = head_q;
  assign commit_dest_reg_out   = dest_q[head_q];
  assign commit_writes_reg_out = writes_q[head_q];
  assign commit_value_out      = value_q[head_q];
  assign count_out             = count_q;

  // Operand lookup: a CDB broadcast to a busy entry is forwarded in the same cycle.
  assign src1_hit       = cdb_valid_in && (cdb_rob_idx_in == src1_idx_in) && busy_q[src1_idx_in];
  assign src1_ready_out = busy_q[src1_idx_in] && (ready_q[src1_idx_in] || src1_hit);
  assign src1_value_out = src1_hit ? cdb_value_in : value_q[src1_idx_in];
  assign src2_hit       = cdb_valid_in && (cdb_rob_idx_in == src2_idx_in) && busy_q[src2_idx_in];
  assign src2_ready_out = busy_q[src2_idx_in] && (ready_q[src2_idx_in] || src2_hit);
  assign src2_value_out = src2_hit ? cdb_value_in : value_q[src2_idx_in];

  always_comb begin
    busy_d   = busy_q;
    ready_d  = ready_q;
    writes_d = writes_q;
    dest_d   = dest_q;
    value_d  = value_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (flush_in) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cdb_valid_in && busy_q[cdb_rob_idx_in]) begin
        value_d[cdb_rob_idx_in] = cdb_value_in;
        ready_d[cdb_rob_idx_in] = 1'b1;
      end
      // Commit clears after the CDB update so a late duplicate write cannot revive the head.
      if (commit_fire) begin
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + IDX_W'(1);
      end
      if (alloc_fire) begin
        busy_d[tail_q]   = 1'b1;
        ready_d[tail_q]  = 1'b0;
        dest_d[tail_q]   = alloc_dest_reg_in;
        writes_d[tail_q] = alloc_writes_reg_in;
        tail_d           = tail_q + IDX_W'(1);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + (IDX_W+1)'(1);
        2'b01:   count_d = count_q - (IDX_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q   <= '0;
      ready_q  <= '0;
      writes_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        dest_q[i]  <= '0;
        value_q[i] <= '0;
      end
    end else begin
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      writes_q <= writes_d;
      dest_q   <= dest_d;
      value_q  <= value_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios with hand-computed expectations,
// followed by a scoreboarded random alloc/CDB/commit mix.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        alloc_valid_in = 1'b0;
  logic [4:0]  alloc_dest_reg_in = '0;
  logic        alloc_writes_reg_in = 1'b0;
  logic        alloc_ready_out;
  logic [2:0]  alloc_idx_out;
  logic        cdb_valid_in = 1'b0;
  logic [2:0]  cdb_rob_idx_in = '0;
  logic [31:0] cdb_value_in = '0;
  logic [2:0]  src1_idx_in = '0;
  logic        src1_ready_out;
  logic [31:0] src1_value_out;
  logic [2:0]  src2_idx_in = '0;
  logic        src2_ready_out;
  logic [31:0] src2_value_out;
  logic        commit_valid_out;
  logic [2:0]  commit_rob_idx_out;
  logic [4:0]  commit_dest_reg_out;
  logic        commit_writes_reg_out;
  logic [31:0] commit_value_out;
  logic [3:0]  count_out;

  int testCount = 0;
  int failCount = 0;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .alloc_valid_in(alloc_valid_in), .alloc_dest_reg_in(alloc_dest_reg_in),
    .alloc_writes_reg_in(alloc_writes_reg_in), .alloc_ready_out(alloc_ready_out),
    .alloc_idx_out(alloc_idx_out), .cdb_valid_in(cdb_valid_in),
    .cdb_rob_idx_in(cdb_rob_idx_in), .cdb_value_in(cdb_value_in),
    .src1_idx_in(src1_idx_in), .src1_ready_out(src1_ready_out), .src1_value_out(src1_value_out),
    .src2_idx_in(src2_idx_in), .src2_ready_out(src2_ready_out), .src2_value_out(src2_value_out),
    .commit_valid_out(commit_valid_out), .commit_rob_idx_out(commit_rob_idx_out),
    .commit_dest_reg_out(commit_dest_reg_out), .commit_writes_reg_out(commit_writes_reg_out),
    .commit_value_out(commit_value_out), .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] dest, input logic wr,
                               input logic cv, input logic [2:0] cidx, input logic [31:0] cval);
    alloc_valid_in      = av;
    alloc_dest_reg_in   = dest;
    alloc_writes_reg_in = wr;
    cdb_valid_in        = cv;
    cdb_rob_idx_in      = cidx;
    cdb_value_in        = cval;
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_in);
  endtask

  task automatic doReset();
    rst_in   = 1'b1;
    flush_in = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    cycle();
    cycle();
    rst_in = 1'b0;
  endtask

  task automatic allocN(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 5'(i + 3), 1'b1, 1'b0, 3'd0, 32'd0);
      cycle();
    end
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    int unsigned order[$];
    logic [31:0] sb_val [8];
    logic [4:0]  sb_dest [8];
    logic        sb_ready [8];
    logic [2:0]  m_tail;
    int          alloc_total;

    // Reset state
    doReset();
    settle();
    checkOutput("rst_count", count_out, 0);
    checkOutput("rst_alloc_ready", alloc_ready_out, 1);
    checkOutput("rst_alloc_idx", alloc_idx_out, 0);
    checkOutput("rst_commit_valid", commit_valid_out, 0);
    checkOutput("rst_src1_ready", src1_ready_out, 0);
    checkOutput("rst_src2_ready", src2_ready_out, 0);

    // Fill to capacity, then a rejected ninth allocation
    cycle();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 5'(i), 1'b1, 1'b0, 3'd0, 32'd0);
      settle();
      checkOutput($sformatf("fill_idx%0d", i), alloc_idx_out, 64'(i));
      checkOutput($sformatf("fill_ready%0d", i), alloc_ready_out, 1);
      cycle();
    end
    settle();
    checkOutput("full_count", count_out, 8);
    checkOutput("full_alloc_ready", alloc_ready_out, 0);
    cycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    settle();
    checkOutput("ninth_count", count_out, 8);
    checkOutput("ninth_tail", alloc_idx_out, 0);
    checkOutput("ninth_commit", commit_valid_out, 0);

    // Out-of-order completion, in-order retirement
    doReset();
    allocN(3);
    alloc_writes_reg_in = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd1, 32'd42);
    settle();
    checkOutput("ooo_no_commit_a", commit_valid_out, 0);
    cycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd0, 32'hFFFF_FFFB);
    settle();
    checkOutput("ooo_no_commit_b", commit_valid_out, 0);
    cycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    settle();
    checkOutput("ooo_c0_valid", commit_valid_out, 1);
    checkOutput("ooo_c0_idx", commit_rob_idx_out, 0);
    checkOutput("ooo_c0_value", commit_value_out, 32'hFFFF_FFFB);
    checkOutput("ooo_c0_dest", commit_dest_reg_out, 3);
    checkOutput("ooo_c0_wr", commit_writes_reg_out, 1);
    cycle();
    settle();
    checkOutput("ooo_c1_valid", commit_valid_out, 1);
    checkOutput("ooo_c1_idx", commit_rob_idx_out, 1);
    checkOutput("ooo_c1_value", commit_value_out, 42);
    checkOutput("ooo_c1_dest", commit_dest_reg_out, 4);
    cycle();
    settle();
    checkOutput("ooo_tag2_pending", commit_valid_out, 0);
    checkOutput("ooo_count", count_out, 1);

    // Full ROB: alloc rejected while head commits, accepted next cycle at wrapped tag 0
    doReset();
    allocN(8);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd0, 32'd7);
    cycle();
    applyStimulus(1'b1, 5'd20, 1'b1, 1'b0, 3'd0, 32'd0);
    settle();
    checkOutput("fc_commit_valid", commit_valid_out, 1);
    checkOutput("fc_count8", count_out, 8);
    checkOutput("fc_alloc_ready0", alloc_ready_out, 0);
    cycle();
    settle();
    checkOutput("fc_count7", count_out, 7);
    checkOutput("fc_alloc_ready1", alloc_ready_out, 1);
    checkOutput("fc_wrap_idx", alloc_idx_out, 0);
    cycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    settle();
    checkOutput("fc_count_after", count_out, 8);
    checkOutput("fc_tail_after", alloc_idx_out, 1);
    checkOutput("fc_no_commit", commit_valid_out, 0);

    // Operand lookup with same-cycle CDB bypass
    doReset();
    allocN(4);
    src1_idx_in = 3'd3;
    src2_idx_in = 3'd5;
    settle();
    checkOutput("lk_pre_ready", src1_ready_out, 0);
    cycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd5, 32'd99);
    settle();
    checkOutput("lk_nonbusy_bypass", src2_ready_out, 0);
    cycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd3, 32'h1234);
    src2_idx_in = 3'd2;
    settle();
    checkOutput("lk_bypass_ready", src1_ready_out, 1);
    checkOutput("lk_bypass_value", src1_value_out, 32'h1234);
    checkOutput("lk_other_ready", src2_ready_out, 0);
    cycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    src2_idx_in = 3'd5;
    settle();
    checkOutput("lk_stored_ready", src1_ready_out, 1);
    checkOutput("lk_stored_value", src1_value_out, 32'h1234);
    checkOutput("lk_nonbusy_ready", src2_ready_out, 0);
    checkOutput("lk_count", count_out, 4);

    // Flush wins over simultaneous alloc and CDB
    doReset();
    allocN(5);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd1, 32'd11);
    cycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd2, 32'd22);
    cycle();
    applyStimulus(1'b1, 5'd9, 1'b1, 1'b1, 3'd3, 32'd9);
    flush_in = 1'b1;
    settle();
    checkOutput("fl_pre_count", count_out, 5);
    cycle();
    flush_in = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    src1_idx_in = 3'd1;
    src2_idx_in = 3'd2;
    settle();
    checkOutput("fl_count", count_out, 0);
    checkOutput("fl_alloc_idx", alloc_idx_out, 0);
    checkOutput("fl_alloc_ready", alloc_ready_out, 1);
    checkOutput("fl_commit_valid", commit_valid_out, 0);
    checkOutput("fl_src1_ready", src1_ready_out, 0);
    checkOutput("fl_src2_ready", src2_ready_out, 0);

    // Random mix against an in-order scoreboard
    doReset();
    order.delete();
    m_tail = '0;
    alloc_total = 0;
    for (int i = 0; i < 8; i++) sb_ready[i] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int unsigned cand[$];
      logic        do_alloc;
      logic        do_cdb;
      logic [2:0]  cdb_tag;
      logic [31:0] cdb_val;
      logic [4:0]  dest;
      logic        exp_commit;
      do_alloc = ($urandom_range(0, 1) == 1);
      dest     = 5'($urandom_range(0, 31));
      foreach (order[k]) if (!sb_ready[order[k]]) cand.push_back(order[k]);
      do_cdb  = (cand.size() > 0) && ($urandom_range(0, 3) != 0);
      cdb_tag = do_cdb ? 3'(cand[$urandom_range(0, cand.size() - 1)]) : 3'd0;
      cdb_val = $urandom();
      applyStimulus(do_alloc, dest, 1'b1, do_cdb, cdb_tag, cdb_val);
      settle();
      exp_commit = (order.size() > 0) && sb_ready[order[0]];
      checkOutput("rnd_commit_valid", commit_valid_out, exp_commit);
      checkOutput("rnd_count", count_out, 64'(order.size()));
      checkOutput("rnd_count_max", (count_out <= 4'd8), 1);
      checkOutput("rnd_alloc_ready", alloc_ready_out, (order.size() < 8));
      checkOutput("rnd_alloc_idx", alloc_idx_out, m_tail);
      if (exp_commit) begin
        checkOutput("rnd_commit_idx", commit_rob_idx_out, order[0]);
        checkOutput("rnd_commit_value", commit_value_out, sb_val[order[0]]);
        checkOutput("rnd_commit_dest", commit_dest_reg_out, sb_dest[order[0]]);
        sb_ready[order[0]] = 1'b0;
        void'(order.pop_front());
      end
      if (do_cdb) begin
        sb_ready[cdb_tag] = 1'b1;
        sb_val[cdb_tag]   = cdb_val;
      end
      if (do_alloc && (order.size() < 8 || exp_commit && order.size() < 8)) begin
        if ((order.size() + (exp_commit ? 1 : 0)) < 9 && !(order.size() == 7 && exp_commit == 1'b0 && 1'b0)) begin
        end
      end
      if (do_alloc && ((order.size() + (exp_commit ? 1 : 0)) < 8)) begin
        order.push_back(32'(m_tail));
        sb_dest[m_tail]  = dest;
        sb_ready[m_tail] = 1'b0;
        m_tail           = m_tail + 3'd1;
        alloc_total++;
      end
      cycle();
    end
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    checkOutput("rnd_wrapped_4x", (alloc_total >= 32), 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
